axis_bridge_fifo: RTL and testbench
===================================

Name: axis_bridge_fifo

Overview:
Parametrised successor to the DMA-facing AXI-Stream bridge between AXI DMA and the transpose-convolution core.
- MM2S path: DMA stream into a FIFO, read by user logic. S2MM path: user logic into a FIFO, out to DMA S2MM.
- New capabilities: generic width and depth, tlast carried through MM2S, automatic tlast generation on S2MM from a programmable packet length, synchronous flush, level and status outputs.
- Uses in-house FIFOs (no vendor macros). No unregistered-valid hazard on S2MM: ready/valid is honoured end-to-end.

Parameters:
DATA_W, 64, tdata width in bits; multiple of 8.
DEPTH, 128, entries per FIFO; power of two, minimum 4.
CNT_W, $clog2(DEPTH)+1, width of level counts.
LEN_W, 16, width of the S2MM packet-length register.

Ports:
aclk  in  1  clock
aresetn  in  1  reset, synchronous, active-low
flush  in  1  synchronous clear of both FIFOs and the packet counter
s_axis_tdata  in  DATA_W  DMA MM2S data
s_axis_tvalid  in  1  DMA MM2S valid
s_axis_tlast  in  1  DMA MM2S last
s_axis_tready  out  1  MM2S FIFO not full
m_axis_tdata  out  DATA_W  to DMA S2MM
m_axis_tvalid  out  1  S2MM FIFO not empty
m_axis_tlast  out  1  stored or generated last
m_axis_tready  in  1  DMA S2MM ready
mm2s_data  out  DATA_W  head of MM2S FIFO
mm2s_last  out  1  tlast of head entry
mm2s_valid  out  1  MM2S FIFO not empty
mm2s_ready  in  1  user pops on valid&ready
mm2s_count  out  CNT_W  MM2S occupancy
s2mm_data  in  DATA_W  user data
s2mm_valid  in  1  user valid
s2mm_last  in  1  user last; used only when pkt_len==0
s2mm_ready  out  1  S2MM FIFO not full
s2mm_count  out  CNT_W  S2MM occupancy
pkt_len  in  LEN_W  beats per S2MM packet; 0 = user-framed
pkt_sent  out  1  one-cycle pulse per tlast beat accepted by the DMA

Behaviour:
Reset (aresetn low at a clock edge):
- All pointers, counts and the beat counter go to 0.
- All valid and ready outputs are 0 during reset. Readies rise the cycle after reset is released.
- pkt_sent = 0; data outputs are don't-care.
- Reset mid-packet drops all content. No partial tlast is emitted.

FIFO (each path):
- First-word-fall-through. A beat written at edge N appears on the output valid/data after edge N.
- Push on valid&ready. ready = !full, taken from registered state only. A pop in the same cycle does not raise ready while the FIFO is full.
- Pop on valid&ready. valid = !empty. No pop is possible when empty, so a simultaneous push/pop while empty is only a push.
- Simultaneous push and pop while neither full nor empty: count unchanged, data order preserved.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. count = wr_ptr − rd_ptr, registered, range 0..DEPTH.
- Stored entry width is DATA_W+1 (data plus last).

S2MM framing:
- beat_cnt (LEN_W bits) increments on each accepted S2MM push.
- len_q latches pkt_len when beat_cnt==0 and a push occurs. pkt_len may change between packets, not within one.
- Stored last = (len_q_eff != 0) ? (beat_cnt == len_q_eff−1) : s2mm_last. len_q_eff is pkt_len on the first beat and len_q afterwards.
- beat_cnt returns to 0 after a push that carries last.
- pkt_sent pulses for the cycle after m_axis_tvalid&m_axis_tready&m_axis_tlast.

Flush:
- Takes effect at the edge it is sampled. Clears both FIFOs and beat_cnt.
- Overrides simultaneous pushes and pops; beats in that cycle are lost. Both readies are 0 during the flush cycle.
- Issued only while the DMA is idle (software contract).

Decomposition:
- Package axis_bridge_pkg: default widths, the CNT_W helper function, and the packed entry type {last, data}.
- Sub-module axis_sync_fifo(W, DEPTH): FWFT FIFO with flush and count, instantiated twice.
- Framing counter and pkt_sent logic live in the top.
- Expected size about 200 RTL lines.

Test Plan:
1. Reset then idle -> readies 1 from the cycle after release; counts 0; valids 0; pkt_sent 0.
2. DMA pushes 128 beats (data = index, last on beat 127) with mm2s_ready=0 -> s_axis_tready drops after beat 128 and mm2s_count=128. Then mm2s_ready=1 -> data 0..127 in order, mm2s_last only on 127, count back to 0.
3. pkt_len=4, user sends 10 beats with s2mm_last=0, m_axis_tready=1 -> m_axis_tlast on output beats 3 and 7. Two pkt_sent pulses. beat_cnt=2 at the end.
4. pkt_len=0, user asserts s2mm_last on beat 5 -> m_axis_tlast only on beat 5. Change pkt_len to 3 mid-packet -> framing of the current packet is unchanged.
5. Random valid/ready toggling on both paths (10k beats, 50% duty) -> scoreboard exact ordering; no loss or duplication; counts match the model every cycle.
6. Flush with 17 beats in S2MM and 9 in MM2S, plus pushes in the same cycle -> both counts 0 the next cycle, valids 0, beat_cnt 0. The next packet with pkt_len=2 produces tlast on its 2nd beat.

Source files
------------

// File: rtl/axis_bridge_pkg.sv
// Shared widths, the level-count width helper and the stored FIFO entry layout
// for the DMA-facing AXI-Stream bridge.
package axis_bridge_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_DEPTH  = 128;
    localparam int DEF_LEN_W  = 16;

    // Level counts must hold 0..DEPTH inclusive, hence one bit above the address width.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Stored FIFO entry at the default width: tlast sits above the data bits.
    typedef struct packed {
        logic                  last;
        logic [DEF_DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/axis_sync_fifo.sv
// First-word-fall-through synchronous FIFO with synchronous flush and a registered
// occupancy count. Ready depends only on registered state (and flush), never on the
// read side, so a pop while full does not open the write port in the same cycle.
module axis_sync_fifo #(
    parameter  int W     = 65,
    parameter  int DEPTH = 128,
    localparam int AW    = $clog2(DEPTH),
    localparam int PW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          wr_valid_i,
    output logic          wr_ready_o,
    output logic [W-1:0]  rd_data_o,
    output logic          rd_valid_o,
    input  logic          rd_ready_i,
    output logic [PW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          en_q;
    logic          full, empty, push, pop;

    // en_q holds the write port closed until the first edge after reset release.
    assign full       = (count_q == PW'(DEPTH));
    assign empty      = (count_q == '0);
    assign wr_ready_o = en_q & ~full & ~flush_i;
    assign rd_valid_o = ~empty;
    assign push       = wr_valid_i & wr_ready_o;
    assign pop        = rd_valid_o & rd_ready_i & ~flush_i;
    assign rd_data_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign count_o    = count_q;

    // Next pointer/count: flush wins over any push or pop in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = wr_ptr_d - rd_ptr_d;
    end

    // Pointer, count and enable registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            en_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            en_q     <= 1'b1;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/axis_bridge_fifo.sv
// DMA-facing AXI-Stream bridge: MM2S FIFO (DMA -> user, tlast carried through) and
// S2MM FIFO (user -> DMA) with tlast either user-framed or generated from pkt_len.
module axis_bridge_fifo
    import axis_bridge_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = cnt_w(DEPTH),
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              flush,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] mm2s_data,
    output logic              mm2s_last,
    output logic              mm2s_valid,
    input  logic              mm2s_ready,
    output logic [CNT_W-1:0]  mm2s_count,
    input  logic [DATA_W-1:0] s2mm_data,
    input  logic              s2mm_valid,
    input  logic              s2mm_last,
    output logic              s2mm_ready,
    output logic [CNT_W-1:0]  s2mm_count,
    input  logic [LEN_W-1:0]  pkt_len,
    output logic              pkt_sent
);

    localparam int EW = DATA_W + 1;

    logic [EW-1:0]    mm2s_rd;
    logic [EW-1:0]    s2mm_wr;
    logic [EW-1:0]    s2mm_rd;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] len_eff;
    logic             gen_last;
    logic             s2mm_push;
    logic             pkt_sent_q, pkt_sent_d;

    axis_sync_fifo #(.W(EW), .DEPTH(DEPTH)) u_mm2s_fifo (
        .clk_i      (aclk),
        .rst_ni     (aresetn),
        .flush_i    (flush),
        .wr_data_i  ({s_axis_tlast, s_axis_tdata}),
        .wr_valid_i (s_axis_tvalid),
        .wr_ready_o (s_axis_tready),
        .rd_data_o  (mm2s_rd),
        .rd_valid_o (mm2s_valid),
        .rd_ready_i (mm2s_ready),
        .count_o    (mm2s_count)
    );

    assign mm2s_data = mm2s_rd[DATA_W-1:0];
    assign mm2s_last = mm2s_rd[DATA_W];

    assign s2mm_push = s2mm_valid & s2mm_ready;
    assign s2mm_wr   = {gen_last, s2mm_data};

    axis_sync_fifo #(.W(EW), .DEPTH(DEPTH)) u_s2mm_fifo (
        .clk_i      (aclk),
        .rst_ni     (aresetn),
        .flush_i    (flush),
        .wr_data_i  (s2mm_wr),
        .wr_valid_i (s2mm_valid),
        .wr_ready_o (s2mm_ready),
        .rd_data_o  (s2mm_rd),
        .rd_valid_o (m_axis_tvalid),
        .rd_ready_i (m_axis_tready),
        .count_o    (s2mm_count)
    );

    assign m_axis_tdata = s2mm_rd[DATA_W-1:0];
    assign m_axis_tlast = s2mm_rd[DATA_W];
    assign pkt_sent     = pkt_sent_q;

    // Packet framing: the length is sampled on a packet's first beat so a pkt_len
    // change mid-packet only affects the next packet; zero length means user-framed.
    always_comb begin
        len_eff    = (beat_cnt_q == '0) ? pkt_len : len_q;
        gen_last   = (len_eff != '0) ? (beat_cnt_q == len_eff - LEN_W'(1)) : s2mm_last;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        if (flush) begin
            beat_cnt_d = '0;
        end else if (s2mm_push) begin
            if (beat_cnt_q == '0) len_d = pkt_len;
            beat_cnt_d = gen_last ? '0 : beat_cnt_q + LEN_W'(1);
        end
        pkt_sent_d = m_axis_tvalid & m_axis_tready & m_axis_tlast & ~flush;
    end

    // Framing counter, latched length and the registered pkt_sent pulse.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            beat_cnt_q <= '0;
            len_q      <= '0;
            pkt_sent_q <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
            pkt_sent_q <= pkt_sent_d;
        end
    end

endmodule

// File: tb/tb_axis_bridge_fifo.sv
// Bench for axis_bridge_fifo: queue-based reference model updated on each rising
// edge, outputs compared on each falling edge, directed scenarios plus random traffic.
module tb_axis_bridge_fifo;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 128;
    localparam int LEN_W  = 16;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic              flush;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tlast;
    logic              s_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;
    logic [DATA_W-1:0] mm2s_data;
    logic              mm2s_last;
    logic              mm2s_valid;
    logic              mm2s_ready;
    logic [CNT_W-1:0]  mm2s_count;
    logic [DATA_W-1:0] s2mm_data;
    logic              s2mm_valid;
    logic              s2mm_last;
    logic              s2mm_ready;
    logic [CNT_W-1:0]  s2mm_count;
    logic [LEN_W-1:0]  pkt_len;
    logic              pkt_sent;

    always #5 aclk = ~aclk;

    axis_bridge_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .flush         (flush),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .mm2s_data     (mm2s_data),
        .mm2s_last     (mm2s_last),
        .mm2s_valid    (mm2s_valid),
        .mm2s_ready    (mm2s_ready),
        .mm2s_count    (mm2s_count),
        .s2mm_data     (s2mm_data),
        .s2mm_valid    (s2mm_valid),
        .s2mm_last     (s2mm_last),
        .s2mm_ready    (s2mm_ready),
        .s2mm_count    (s2mm_count),
        .pkt_len       (pkt_len),
        .pkt_sent      (pkt_sent)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each path is a plain queue of {last, data}.
    typedef logic [DATA_W:0] ent_t;
    ent_t mq[$];
    ent_t sq[$];
    bit   m_en    = 1'b0;
    int   m_beat  = 0;
    int   m_len   = 0;
    bit   m_pkt   = 1'b0;
    bit   started = 1'b0;
    int   s_out_idx = 0;
    int   last_idx[$];
    int   pkt_pulses = 0;

    initial begin : model
        bit mpush, mpop, spush, spop, lst;
        int eff;
        forever begin
            @(posedge aclk);
            started = 1'b1;
            if (!aresetn) begin
                mq.delete(); sq.delete();
                m_en = 1'b0; m_beat = 0; m_len = 0; m_pkt = 1'b0;
            end else if (flush) begin
                mq.delete(); sq.delete();
                m_beat = 0; m_pkt = 1'b0; m_en = 1'b1;
            end else begin
                mpush = s_axis_tvalid && m_en && (mq.size() < DEPTH);
                mpop  = mm2s_ready && (mq.size() > 0);
                spush = s2mm_valid && m_en && (sq.size() < DEPTH);
                spop  = m_axis_tready && (sq.size() > 0);
                m_pkt = spop && sq[0][DATA_W];
                if (mpop) void'(mq.pop_front());
                if (mpush) mq.push_back({s_axis_tlast, s_axis_tdata});
                if (spop) begin
                    if (sq[0][DATA_W]) last_idx.push_back(s_out_idx);
                    s_out_idx++;
                    void'(sq.pop_front());
                end
                if (spush) begin
                    eff = (m_beat == 0) ? int'(pkt_len) : m_len;
                    lst = (eff != 0) ? (m_beat == eff - 1) : s2mm_last;
                    if (m_beat == 0) m_len = int'(pkt_len);
                    m_beat = lst ? 0 : m_beat + 1;
                    sq.push_back({lst, s2mm_data});
                end
                m_en = 1'b1;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    initial begin : compare
        forever begin
            @(negedge aclk);
            if (started) begin
                chk("s_axis_tready", 64'(s_axis_tready), 64'(m_en && mq.size() < DEPTH && !flush));
                chk("s2mm_ready", 64'(s2mm_ready), 64'(m_en && sq.size() < DEPTH && !flush));
                chk("mm2s_valid", 64'(mm2s_valid), 64'(mq.size() > 0));
                chk("m_axis_tvalid", 64'(m_axis_tvalid), 64'(sq.size() > 0));
                chk("mm2s_count", 64'(mm2s_count), 64'(mq.size()));
                chk("s2mm_count", 64'(s2mm_count), 64'(sq.size()));
                chk("pkt_sent", 64'(pkt_sent), 64'(m_pkt));
                if (mq.size() > 0) begin
                    chk("mm2s_data", mm2s_data, mq[0][DATA_W-1:0]);
                    chk("mm2s_last", 64'(mm2s_last), 64'(mq[0][DATA_W]));
                end
                if (sq.size() > 0) begin
                    chk("m_axis_tdata", m_axis_tdata, sq[0][DATA_W-1:0]);
                    chk("m_axis_tlast", 64'(m_axis_tlast), 64'(sq[0][DATA_W]));
                end
                if (pkt_sent) pkt_pulses++;
            end
        end
    end

    task automatic step();
        @(negedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        step(); step();
        aresetn = 1'b1;
        step();
    endtask

    initial begin : stim
        int p0;
        aresetn = 1'b0; flush = 1'b0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b0; mm2s_ready = 1'b0;
        s2mm_data = '0; s2mm_valid = 1'b0; s2mm_last = 1'b0; pkt_len = '0;

        // 1: reset then idle
        step(); step(); step();
        chk("rst_s_ready", 64'(s_axis_tready), 64'd0);
        chk("rst_s2mm_ready", 64'(s2mm_ready), 64'd0);
        aresetn = 1'b1;
        step();
        chk("rel_s_ready", 64'(s_axis_tready), 64'd1);
        chk("rel_s2mm_ready", 64'(s2mm_ready), 64'd1);
        chk("rel_mm2s_count", 64'(mm2s_count), 64'd0);
        chk("rel_s2mm_count", 64'(s2mm_count), 64'd0);
        chk("rel_valids", 64'({mm2s_valid, m_axis_tvalid}), 64'd0);
        chk("rel_pkt_sent", 64'(pkt_sent), 64'd0);

        // 2: fill MM2S completely, then drain in order
        for (int i = 0; i < DEPTH; i++) begin
            s_axis_tvalid = 1'b1; s_axis_tdata = 64'(i); s_axis_tlast = (i == DEPTH - 1);
            step();
        end
        chk("full_s_ready", 64'(s_axis_tready), 64'd0);
        chk("full_count", 64'(mm2s_count), 64'd128);
        s_axis_tdata = 64'd999; s_axis_tlast = 1'b0;
        step(); step();
        chk("full_count_hold", 64'(mm2s_count), 64'd128);
        s_axis_tvalid = 1'b0;
        mm2s_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_data", mm2s_data, 64'(i));
            chk("drain_last", 64'(mm2s_last), 64'(i == DEPTH - 1));
            step();
        end
        chk("drain_count", 64'(mm2s_count), 64'd0);

        // 3: generated framing with pkt_len=4 over 10 beats
        pkt_len = 16'd4; m_axis_tready = 1'b1;
        last_idx.delete(); s_out_idx = 0; p0 = pkt_pulses;
        for (int i = 0; i < 10; i++) begin
            s2mm_valid = 1'b1; s2mm_data = 64'(100 + i); s2mm_last = 1'b0;
            step();
        end
        s2mm_valid = 1'b0;
        repeat (4) step();
        chk("len4_nlast", 64'(last_idx.size()), 64'd2);
        if (last_idx.size() == 2) begin
            chk("len4_last0", 64'(last_idx[0]), 64'd3);
            chk("len4_last1", 64'(last_idx[1]), 64'd7);
        end
        chk("len4_pulses", 64'(pkt_pulses - p0), 64'd2);
        chk("len4_beat_cnt", 64'(m_beat), 64'd2);

        // 4: user framing, pkt_len changed mid-packet
        do_reset();
        pkt_len = '0; m_axis_tready = 1'b1;
        last_idx.delete(); s_out_idx = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) pkt_len = 16'd3;
            s2mm_valid = 1'b1; s2mm_data = 64'(200 + i); s2mm_last = (i == 5);
            step();
        end
        s2mm_valid = 1'b0; s2mm_last = 1'b0;
        repeat (4) step();
        chk("user_nlast", 64'(last_idx.size()), 64'd1);
        if (last_idx.size() == 1) chk("user_last_idx", 64'(last_idx[0]), 64'd5);

        // 5: random traffic on both paths
        for (int cyc = 0; cyc < 24000; cyc++) begin
            s_axis_tvalid = 1'($urandom_range(0, 1));
            s_axis_tdata  = {$urandom, $urandom};
            s_axis_tlast  = 1'($urandom_range(0, 1));
            s2mm_valid    = 1'($urandom_range(0, 1));
            s2mm_data     = {$urandom, $urandom};
            s2mm_last     = ($urandom_range(0, 3) == 0);
            mm2s_ready    = ($urandom_range(0, 3) < ((cyc < 4000) ? 1 : 2));
            m_axis_tready = ($urandom_range(0, 3) < ((cyc < 4000) ? 1 : 2));
            if ($urandom_range(0, 63) == 0) pkt_len = 16'($urandom_range(0, 5));
            step();
        end
        s_axis_tvalid = 1'b0; s2mm_valid = 1'b0;
        mm2s_ready = 1'b1; m_axis_tready = 1'b1;
        repeat (DEPTH + 4) step();
        chk("rand_mm2s_empty", 64'(mm2s_count), 64'd0);
        chk("rand_s2mm_empty", 64'(s2mm_count), 64'd0);

        // 6: flush with content in both FIFOs and pushes in the same cycle
        do_reset();
        pkt_len = '0; mm2s_ready = 1'b0; m_axis_tready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            s_axis_tvalid = (i < 9); s_axis_tdata = 64'(300 + i); s_axis_tlast = 1'b0;
            s2mm_valid = 1'b1; s2mm_data = 64'(400 + i); s2mm_last = 1'b0;
            step();
        end
        chk("pre_flush_mm2s", 64'(mm2s_count), 64'd9);
        chk("pre_flush_s2mm", 64'(s2mm_count), 64'd17);
        flush = 1'b1; s_axis_tvalid = 1'b1; s2mm_valid = 1'b1;
        #1;
        chk("flush_s_ready", 64'(s_axis_tready), 64'd0);
        chk("flush_s2mm_ready", 64'(s2mm_ready), 64'd0);
        step();
        flush = 1'b0; s_axis_tvalid = 1'b0; s2mm_valid = 1'b0;
        chk("post_flush_mm2s", 64'(mm2s_count), 64'd0);
        chk("post_flush_s2mm", 64'(s2mm_count), 64'd0);
        chk("post_flush_valids", 64'({mm2s_valid, m_axis_tvalid}), 64'd0);
        chk("post_flush_beat", 64'(m_beat), 64'd0);
        pkt_len = 16'd2; m_axis_tready = 1'b1;
        last_idx.delete(); s_out_idx = 0;
        for (int i = 0; i < 3; i++) begin
            s2mm_valid = 1'b1; s2mm_data = 64'(500 + i);
            step();
        end
        s2mm_valid = 1'b0;
        repeat (4) step();
        chk("len2_nlast", 64'(last_idx.size()), 64'd1);
        if (last_idx.size() == 1) chk("len2_last_idx", 64'(last_idx[0]), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
